// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and its environment
// (imem, hazard unit, ID-stage PC control, EX flag writes).
interface pc_sequencer_if;
  logic        imem_rdy;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        hlt_id;
  logic [2:0]  flag_we;
  logic [2:0]  flags_in;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_req;
  logic        if_id_wen;
  logic        if_id_flush;
  logic [2:0]  flags;
  logic        halted;
  logic        fetch_err;

  modport master (
    output imem_rdy, stall, br_taken, br_target, hlt_id, flag_we, flags_in,
    input  pc, pc_plus2, fetch_req, if_id_wen, if_id_flush, flags, halted, fetch_err
  );

  modport slave (
    input  imem_rdy, stall, br_taken, br_target, hlt_id, flag_we, flags_in,
    output pc, pc_plus2, fetch_req, if_id_wen, if_id_flush, flags, halted, fetch_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC and N/V/Z flag owner; sequences fetch around imem wait
// states, hazard stalls, ID-stage branch redirects and HLT.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          WAIT_LIMIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  state_t      state, state_next;
  logic [15:0] pc_q, pc_next;
  logic [15:0] pend_target, pend_target_next;
  logic        pend_valid, pend_valid_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic        fetch_err_q, fetch_err_next;
  logic [2:0]  flags_q;
  logic        fetch_req_c, if_id_wen_c, if_id_flush_c, halted_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      pend_target <= 16'h0000;
      pend_valid  <= 1'b0;
      wait_cnt    <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state       <= state_next;
      pc_q        <= pc_next;
      pend_target <= pend_target_next;
      pend_valid  <= pend_valid_next;
      wait_cnt    <= wait_cnt_next;
      fetch_err_q <= fetch_err_next;
    end
  end

  // Flags keep updating in every state so EX can drain after HLT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 3'b000;
    else     flags_q <= (bus.flags_in & bus.flag_we) | (flags_q & ~bus.flag_we);
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc_q;
    pend_target_next = pend_target;
    pend_valid_next  = pend_valid;
    wait_cnt_next    = wait_cnt;
    fetch_err_next   = fetch_err_q;
    case (state)
      RUN: begin
        if (!bus.stall) begin
          if (bus.hlt_id) begin
            state_next = HALTED;
          end else if (bus.imem_rdy) begin
            pc_next = bus.br_taken ? bus.br_target : pc_q + 16'd2;
          end else begin
            state_next    = MEM_WAIT;
            wait_cnt_next = 8'd1;
            if (bus.br_taken) begin
              pend_target_next = bus.br_target;
              pend_valid_next  = 1'b1;
            end
          end
        end
      end
      MEM_WAIT: begin
        if (!bus.stall && bus.hlt_id) begin
          state_next      = HALTED;
          pend_valid_next = 1'b0;
        end else if (bus.imem_rdy) begin
          // A stalled ready cycle just parks here with the counter frozen.
          if (!bus.stall) begin
            if (bus.br_taken)    pc_next = bus.br_target;
            else if (pend_valid) pc_next = pend_target;
            else                 pc_next = pc_q + 16'd2;
            pend_valid_next = 1'b0;
            wait_cnt_next   = 8'd0;
            state_next      = RUN;
          end
        end else begin
          if (!bus.stall && bus.br_taken) begin
            pend_target_next = bus.br_target;
            pend_valid_next  = 1'b1;
          end
          if (wait_cnt != 8'd255) wait_cnt_next = wait_cnt + 8'd1;
          if (wait_cnt >= WAIT_LIM) fetch_err_next = 1'b1;
        end
      end
      HALTED: begin
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    fetch_req_c   = 1'b1;
    if_id_wen_c   = 1'b0;
    if_id_flush_c = 1'b0;
    halted_c      = 1'b0;
    case (state)
      RUN: begin
        if (!bus.stall) begin
          if (bus.hlt_id) begin
            if_id_flush_c = 1'b1;
          end else if (bus.imem_rdy) begin
            if_id_wen_c   = 1'b1;
            if_id_flush_c = bus.br_taken;
          end
        end
      end
      MEM_WAIT: begin
        if (!bus.stall) begin
          if (bus.hlt_id) begin
            if_id_flush_c = 1'b1;
          end else if (bus.imem_rdy) begin
            if_id_wen_c   = 1'b1;
            if_id_flush_c = bus.br_taken | pend_valid;
          end
        end
      end
      HALTED: begin
        fetch_req_c = 1'b0;
        halted_c    = 1'b1;
      end
      default: fetch_req_c = 1'b1;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus2    = pc_q + 16'd2;
  assign bus.fetch_req   = fetch_req_c;
  assign bus.if_id_wen   = if_id_wen_c;
  assign bus.if_id_flush = if_id_flush_c;
  assign bus.flags       = flags_q;
  assign bus.halted      = halted_c;
  assign bus.fetch_err   = fetch_err_q;

endmodule
